// File: rtl/wave_cmd_gen_pkg.sv
// Shared types for the waveform command generator: opcodes, wave shapes,
// receiver FSM states and the SET_WAVE reserved-argument mask.
package wave_pkg;

    typedef enum logic [1:0] {
        OP_WAVE = 2'd0,
        OP_FREQ = 2'd1,
        OP_AMP  = 2'd2,
        OP_DC   = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        W_DC     = 2'd0,
        W_SQUARE = 2'd1,
        W_SAW    = 2'd2,
        W_TRI    = 2'd3
    } wave_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DATA_HI  = 2'd1,
        DATA_LO  = 2'd2,
        DATA_ONE = 2'd3
    } rx_state_e;

    // Any set bit here in a SET_WAVE argument makes the header reserved.
    localparam logic [5:0] WAVE_ARG_MASK = 6'b111100;

endpackage

// File: rtl/wave_cmd_gen_shaper.sv
// Combinational sample shaper: maps the top 8 phase bits to the selected
// wave shape, scaled by (amp+1)/256; DC bypasses scaling.
module wave_shaper
    import wave_pkg::*;
(
    input  logic [7:0] i_p,
    input  wave_e      i_wave,
    input  logic [7:0] i_amp,
    input  logic [7:0] i_dc,
    output logic [7:0] o_sample
);

    logic [7:0]  w_shape;
    logic [15:0] w_prod;

    always_comb begin
        w_shape = 8'h00;
        case (i_wave)
            W_SQUARE: w_shape = i_p[7] ? 8'hFF : 8'h00;
            W_SAW:    w_shape = i_p;
            W_TRI:    w_shape = i_p[7] ? ~{i_p[6:0], 1'b0} : {i_p[6:0], 1'b0};
            default:  w_shape = 8'h00;
        endcase
        // 255 * 256 still fits in 16 bits, so amp=0xFF is exact unity gain.
        w_prod   = {8'h00, w_shape} * ({8'h00, i_amp} + 16'd1);
        o_sample = (i_wave == W_DC) ? i_dc : w_prod[15:8];
    end

endmodule

// File: rtl/wave_cmd_gen.sv
// Command-driven waveform generator: decodes 1-3 byte frames into settings and
// produces one DAC sample per prescaler tick from a phase accumulator.
module wave_cmd_gen
    import wave_pkg::*;
#(
    parameter int PRESCALE = 12,
    parameter int ACC_W    = 16,
    parameter int TIMEOUT  = 1200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] command,
    input  logic       command_signal,
    output logic [7:0] dac_out,
    output logic       sample_valid,
    output logic       cmd_error,
    output rx_state_e  dbg_state
);

    localparam int PS_W = $clog2(PRESCALE);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    rx_state_e        r_state;
    rx_state_e        w_next;
    opcode_e          r_op;
    opcode_e          w_opcode;
    logic [TO_W-1:0]  r_to_cnt;
    logic [7:0]       r_tw_hi;
    wave_e            r_wave;
    logic [ACC_W-1:0] r_tw;
    logic [7:0]       r_amp;
    logic [7:0]       r_dc;
    logic [ACC_W-1:0] r_phase;
    logic [PS_W-1:0]  r_presc;
    logic [7:0]       r_dac;
    logic             r_valid;
    logic             r_err;

    logic             w_tick;
    logic [ACC_W-1:0] w_phase_next;
    logic [7:0]       w_sample;
    logic             w_commit_wave;
    logic             w_commit_tw;
    logic             w_commit_amp;
    logic             w_commit_dc;
    logic             w_abort;
    logic             w_bad_arg;

    assign w_opcode     = opcode_e'(command[7:6]);
    assign w_tick       = (r_presc == PS_W'(PRESCALE - 1));
    assign w_phase_next = r_phase + r_tw;

    // The sample is built from the post-update phase with pre-commit settings.
    wave_shaper u_shaper (
        .i_p      (w_phase_next[ACC_W-1 -: 8]),
        .i_wave   (r_wave),
        .i_amp    (r_amp),
        .i_dc     (r_dc),
        .o_sample (w_sample)
    );

    always_comb begin
        w_next        = r_state;
        w_commit_wave = 1'b0;
        w_commit_tw   = 1'b0;
        w_commit_amp  = 1'b0;
        w_commit_dc   = 1'b0;
        w_abort       = 1'b0;
        w_bad_arg     = 1'b0;
        case (r_state)
            IDLE: begin
                if (command_signal) begin
                    case (w_opcode)
                        OP_WAVE: begin
                            if ((command[5:0] & WAVE_ARG_MASK) != 6'd0) w_bad_arg = 1'b1;
                            else                                        w_commit_wave = 1'b1;
                        end
                        OP_FREQ: w_next = DATA_HI;
                        OP_AMP:  w_next = DATA_ONE;
                        OP_DC:   w_next = DATA_ONE;
                        default: w_next = IDLE;
                    endcase
                end
            end
            DATA_HI: if (command_signal) w_next = DATA_LO;
            DATA_LO: begin
                if (command_signal) begin
                    w_commit_tw = 1'b1;
                    w_next      = IDLE;
                end
            end
            DATA_ONE: begin
                if (command_signal) begin
                    w_commit_dc  = (r_op == OP_DC);
                    w_commit_amp = (r_op != OP_DC);
                    w_next       = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (r_state != IDLE && !command_signal && r_to_cnt == TO_W'(TIMEOUT - 1)) begin
            w_abort = 1'b1;
            w_next  = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= OP_WAVE;
            r_to_cnt <= '0;
            r_tw_hi  <= 8'h00;
            r_wave   <= W_DC;
            r_tw     <= '0;
            r_amp    <= 8'hFF;
            r_dc     <= 8'h00;
            r_phase  <= '0;
            r_presc  <= '0;
            r_dac    <= 8'h00;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE || command_signal) r_to_cnt <= '0;
            else                                   r_to_cnt <= r_to_cnt + 1'b1;
            if (r_state == IDLE && command_signal)    r_op    <= w_opcode;
            if (r_state == DATA_HI && command_signal) r_tw_hi <= command;

            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            r_valid <= w_tick;
            if (w_tick) begin
                r_phase <= w_phase_next;
                r_dac   <= w_sample;
            end

            // Placed after the tick update so a coincident phase clear wins.
            if (w_commit_wave) begin
                r_wave  <= wave_e'(command[1:0]);
                r_phase <= '0;
            end
            if (w_commit_tw)  r_tw  <= ACC_W'({r_tw_hi, command});
            if (w_commit_amp) r_amp <= command;
            if (w_commit_dc) begin
                r_dc   <= command;
                r_wave <= W_DC;
            end
            if (w_abort || w_bad_arg) r_err <= 1'b1;
        end
    end

    assign dac_out      = r_dac;
    assign sample_valid = r_valid;
    assign cmd_error    = r_err;
    assign dbg_state    = r_state;

endmodule
